axi_burst_master: RTL and testbench
===================================

Name: axi_burst_master

Overview:
Parametrised successor to the single-beat uncached AXI bridge. Sits between the cache/uncached-access arbiter and the AXI3 master port. Issues one outstanding transaction at a time: a single-beat or INCR burst read (line refill), or a buffered burst write (line writeback). Also reports per-transaction response errors.

Parameters:
BURST_MAX, 8, write-buffer depth and maximum beats per transaction (power of 2, 2..16)
RD_ID, 4'b0010, value driven on arid
WR_ID, 4'b0001, value driven on awid and wid

Ports:
aclk  in  1  clock
aresetn  in  1  async active-low reset
ar*/r*/aw*/w*/b*  -  AXI3 master channels, same widths as the existing bridge (id 4, addr/data 32, len 4, size 3, burst 2, lock 2, cache 4, prot 3)
req_valid  in  1  transaction request
req_ready  out  1  request accepted when req_valid&req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  32  start address
req_size  in  2  beat size (0 byte, 1 half, 2 word)
req_len  in  4  beats-1
wr_valid  in  1  write-data beat valid
wr_ready  out  1  write-data beat accepted
wr_data  in  32  write beat data
wr_strb  in  4  write beat byte strobes
rd_valid  out  1  read beat valid (one cycle per beat)
rd_data  out  32  read beat data
rd_last  out  1  last read beat
done  out  1  one-cycle pulse, transaction complete
done_err  out  1  valid with done; 1 if any rresp/bresp != 0 or request illegal

Behaviour:
- Clock aclk; reset aresetn, asynchronous, active-low. Reset: state IDLE, all registered outputs 0 (arvalid, awvalid, wvalid, wlast, rd_valid, rd_last, done, done_err, addresses, lengths, counters). req_ready=1 in IDLE.
- Constants: arburst=awburst=2'b01, lock/cache/prot=0, rready=1, bready=1, arid=RD_ID, awid=wid=WR_ID.
- req_ready = (state==IDLE). On accept, latch addr/size/len/write.
- Illegal request (req_len >= BURST_MAX, or req_size==3): no bus activity; go to DONE, done_err=1.
- Read path: IDLE -> AR. Drive araddr, arlen=len, arsize={0,size}, arvalid=1; hold stable until arready sampled high. AR -> R. Each rvalid beat: rd_valid=1, rd_data=rdata, rd_last=rlast, registered (1-cycle latency). Error flag ORs (rresp!=0). Leave R on rlast -> DONE.
- Write path: IDLE -> WFILL. wr_ready=1 only in WFILL; each accepted beat goes to buffer[fill_cnt], fill_cnt++. After len+1 beats -> AW. Drive awaddr, awlen, awsize, awvalid; hold until awready -> W. Beat counter k: wdata/wstrb=buffer[k], wvalid=1, wlast=(k==len). On wvalid&wready: k++. After the last beat handshakes -> B. On bvalid: error |= (bresp!=0) -> DONE.
- DONE: done=1 for exactly one cycle with done_err, then IDLE. Error flag clears on next accept.
- Valid/data stay stable while waiting for ready (AXI rule). Back-to-back handshakes (ready held high) give one beat per cycle with no bubbles.
- Beats with wrong rid, or rvalid/bvalid outside R/B, are ignored.
- Reset mid-transaction: immediate return to IDLE, outputs cleared, buffer contents don't-care. No completion pulse.
- len=0 is a single beat: wlast/rd_last asserted on beat 0.

Test Plan:
- Reset, then read addr 0x1FC0_0000 size 2 len 0, arready after 2 cycles, rdata 0xDEADBEEF rlast -> one AR (arlen 0, arsize 2); rd_valid/rd_last with 0xDEADBEEF; done=1, done_err=0.
- Read len 7 at 0x0000_1000, rvalid toggling every other cycle -> 8 rd_valid beats in order; rd_last only on the 8th; done after it.
- Write len 7, data 0..7, strb 4'hF; awready and wready stalled randomly -> awlen 7; 8 W beats with data 0..7 in order, wlast only on beat 7; stable while stalled; done after bvalid.
- Write len 0 with bresp=2'b10 -> done_err=1; next read with rresp OKAY gives done_err=0.
- req_len=8 with BURST_MAX=8 -> no arvalid/awvalid; done=1, done_err=1 two cycles after accept.
- Assert aresetn low during W beat 3 -> all valids drop immediately; req_ready=1 after release; new read completes normally.

Source files
------------

// File: rtl/axi_burst_master_if.sv
// AXI3 master-side channel bundle for axi_burst_master.
// The master modport is the bridge; the slave modport is whatever sits on the AXI fabric.
interface axi_burst_master_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI3 burst master: INCR read refill or buffered INCR write-back,
// with a per-transaction error summary reported alongside the done pulse.
//
// state | meaning
// IDLE  | ready for a request
// AR    | read address presented, waiting for arready
// R     | collecting read beats until rlast
// WFILL | filling the write buffer from the requester
// AW    | write address presented, waiting for awready
// W     | streaming buffered beats to the bus
// B     | waiting for the write response
// DONE  | emit done/done_err on the next cycle, then IDLE
module axi_burst_master #(
  parameter int          BURST_MAX = 8,
  parameter logic [3:0]  RD_ID     = 4'b0010,
  parameter logic [3:0]  WR_ID     = 4'b0001
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi_burst_master_if.master   axi,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [31:0]          req_addr,
  input  logic [1:0]           req_size,
  input  logic [3:0]           req_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [31:0]          wr_data,
  input  logic [3:0]           wr_strb,
  output logic                 rd_valid,
  output logic [31:0]          rd_data,
  output logic                 rd_last,
  output logic                 done,
  output logic                 done_err
);

  localparam int         CW   = (BURST_MAX > 2) ? $clog2(BURST_MAX) : 1;
  localparam logic [4:0] BMAX = 5'(BURST_MAX);

  typedef enum logic [2:0] {IDLE, AR, R, WFILL, AW, W, B, DONE} state_t;

  state_t          state;
  logic [31:0]     addr_q;
  logic [1:0]      size_q;
  logic [3:0]      len_q;
  logic            err_q;
  logic            arvalid_q;
  logic            awvalid_q;
  logic            wvalid_q;
  logic            wlast_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic [CW-1:0]   fill_cnt;
  logic [CW-1:0]   beat_cnt;
  logic [CW-1:0]   beat_nxt;
  logic            req_illegal;

  logic [31:0]     buf_data [BURST_MAX];
  logic [3:0]      buf_strb [BURST_MAX];

  assign req_ready   = (state == IDLE);
  assign wr_ready    = (state == WFILL);
  assign req_illegal = ({1'b0, req_len} >= BMAX) || (req_size == 2'd3);
  assign beat_nxt    = beat_cnt + 1'b1;

  assign axi.arid    = RD_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = 1'b1;

  assign axi.awid    = WR_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = {1'b0, size_q};
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = awvalid_q;

  assign axi.wid     = WR_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = wlast_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = 1'b1;

  // Buffer contents are don't-care after reset, so no reset branch here.
  always_ff @(posedge aclk) begin
    if (state == WFILL && wr_valid) begin
      buf_data[fill_cnt] <= wr_data;
      buf_strb[fill_cnt] <= wr_strb;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      fill_cnt  <= '0;
      beat_cnt  <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
      done_err  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
      done_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            size_q   <= req_size;
            len_q    <= req_len;
            fill_cnt <= '0;
            beat_cnt <= '0;
            err_q    <= req_illegal;
            if (req_illegal) begin
              state <= DONE;
            end else if (req_write) begin
              state <= WFILL;
            end else begin
              arvalid_q <= 1'b1;
              state     <= AR;
            end
          end
        end
        AR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            state     <= R;
          end
        end
        R: begin
          if (axi.rvalid && axi.rid == RD_ID) begin
            rd_valid <= 1'b1;
            rd_data  <= axi.rdata;
            rd_last  <= axi.rlast;
            if (axi.rresp != 2'b00) err_q <= 1'b1;
            if (axi.rlast) state <= DONE;
          end
        end
        WFILL: begin
          if (wr_valid) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == len_q[CW-1:0]) begin
              awvalid_q <= 1'b1;
              state     <= AW;
            end
          end
        end
        AW: begin
          if (axi.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wdata_q   <= buf_data[0];
            wstrb_q   <= buf_strb[0];
            wlast_q   <= (len_q == 4'd0);
            beat_cnt  <= '0;
            state     <= W;
          end
        end
        W: begin
          if (axi.wready) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              state    <= B;
            end else begin
              // Preload the next beat so back-to-back wready gives one beat per cycle.
              beat_cnt <= beat_nxt;
              wdata_q  <= buf_data[beat_nxt];
              wstrb_q  <= buf_strb[beat_nxt];
              wlast_q  <= (beat_nxt == len_q[CW-1:0]);
            end
          end
        end
        B: begin
          if (axi.bvalid && axi.bid == WR_ID) begin
            if (axi.bresp != 2'b00) err_q <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done     <= 1'b1;
          done_err <= err_q;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: reads, buffered writes, errors, illegal requests, reset abort.
module tb_axi_burst_master;
  logic        aclk;
  logic        aresetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [3:0]  req_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        done;
  logic        done_err;

  int checks;
  int failures;

  axi_burst_master_if axi();

  axi_burst_master #(.BURST_MAX(8), .RD_ID(4'b0010), .WR_ID(4'b0001)) dut (
    .aclk(aclk), .aresetn(aresetn), .axi(axi),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_err(done_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [3:0] l);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_size  = s;
    req_len   = l;
    tick();
    req_valid = 1'b0;
  endtask

  // Single-beat word read answered immediately; leaves the bench on the done cycle.
  task automatic quick_read(input logic [31:0] a, input logic [31:0] d);
    issue(1'b0, a, 2'd2, 4'd0);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rid = 4'b0010; axi.rdata = d; axi.rlast = 1'b1; axi.rresp = 2'b00;
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick(); tick();
    checks++;
    if (req_ready !== 1'b1 || axi.arvalid !== 1'b0 || axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0
        || rd_valid !== 1'b0 || done !== 1'b0 || done_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: req_ready=%b arvalid=%b awvalid=%b wvalid=%b rd_valid=%b done=%b, required 1,0,0,0,0,0",
               req_ready, axi.arvalid, axi.awvalid, axi.wvalid, rd_valid, done);
    end
    checks++;
    if (axi.arburst !== 2'b01 || axi.rready !== 1'b1 || axi.bready !== 1'b1 || axi.arid !== 4'b0010 || axi.awid !== 4'b0001) begin
      failures++;
      $display("FAIL constants: arburst=%b rready=%b bready=%b arid=%h awid=%h", axi.arburst, axi.rready, axi.bready, axi.arid, axi.awid);
    end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_read_single();
    issue(1'b0, 32'h1FC0_0000, 2'd2, 4'd0);
    checks++;
    if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h1FC0_0000 || axi.arlen !== 4'd0 || axi.arsize !== 3'd2 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL rd1_ar: arvalid=%b araddr=%h arlen=%0d arsize=%0d req_ready=%b, required 1 1fc00000 0 2 0",
               axi.arvalid, axi.araddr, axi.arlen, axi.arsize, req_ready);
    end
    tick(); tick();
    checks++;
    if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h1FC0_0000) begin
      failures++;
      $display("FAIL rd1_ar_hold: arvalid=%b araddr=%h, required 1 1fc00000", axi.arvalid, axi.araddr);
    end
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    checks++;
    if (axi.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd1_ar_drop: arvalid=%b, required 0", axi.arvalid);
    end
    axi.rvalid = 1'b1; axi.rid = 4'b0010; axi.rdata = 32'hDEADBEEF; axi.rlast = 1'b1; axi.rresp = 2'b00;
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF || rd_last !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL rd1_beat: rd_valid=%b rd_data=%h rd_last=%b done=%b, required 1 deadbeef 1 0", rd_valid, rd_data, rd_last, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || done_err !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd1_done: done=%b done_err=%b rd_valid=%b, required 1 0 0", done, done_err, rd_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd1_idle: done=%b req_ready=%b, required 0 1", done, req_ready);
    end
  endtask

  task automatic test_read_burst();
    issue(1'b0, 32'h0000_1000, 2'd2, 4'd7);
    checks++;
    if (axi.arvalid !== 1'b1 || axi.arlen !== 4'd7 || axi.araddr !== 32'h0000_1000) begin
      failures++;
      $display("FAIL rd8_ar: arvalid=%b arlen=%0d araddr=%h, required 1 7 00001000", axi.arvalid, axi.arlen, axi.araddr);
    end
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    // Foreign-ID beat must be ignored.
    axi.rvalid = 1'b1; axi.rid = 4'h5; axi.rdata = 32'h5555_5555; axi.rlast = 1'b1; axi.rresp = 2'b10;
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd8_wrong_id: rd_valid=%b, required 0", rd_valid);
    end
    for (int i = 0; i < 8; i++) begin
      axi.rvalid = 1'b1; axi.rid = 4'b0010; axi.rdata = 32'hA000_0000 + 32'(i); axi.rlast = (i == 7);
      tick();
      axi.rvalid = 1'b0; axi.rlast = 1'b0;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'hA000_0000 + 32'(i) || rd_last !== (i == 7)) begin
        failures++;
        $display("FAIL rd8_beat%0d: rd_valid=%b rd_data=%h rd_last=%b, required 1 %h %b",
                 i, rd_valid, rd_data, rd_last, 32'hA000_0000 + 32'(i), (i == 7));
      end
      tick();
      checks++;
      if (rd_valid !== 1'b0 || done !== (i == 7)) begin
        failures++;
        $display("FAIL rd8_gap%0d: rd_valid=%b done=%b, required 0 %b", i, rd_valid, done, (i == 7));
      end
    end
    checks++;
    if (done_err !== 1'b0) begin
      failures++;
      $display("FAIL rd8_err: done_err=%b, required 0", done_err);
    end
    tick();
  endtask

  task automatic test_write_burst();
    logic hs;
    int   beat;
    issue(1'b1, 32'h0000_2000, 2'd2, 4'd7);
    checks++;
    if (wr_ready !== 1'b1 || axi.awvalid !== 1'b0) begin
      failures++;
      $display("FAIL wr8_fill: wr_ready=%b awvalid=%b, required 1 0", wr_ready, axi.awvalid);
    end
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = 32'(i); wr_strb = 4'hF;
      tick();
    end
    wr_valid = 1'b0;
    checks++;
    if (axi.awvalid !== 1'b1 || axi.awlen !== 4'd7 || axi.awaddr !== 32'h0000_2000 || axi.awsize !== 3'd2 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL wr8_aw: awvalid=%b awlen=%0d awaddr=%h awsize=%0d wr_ready=%b, required 1 7 00002000 2 0",
               axi.awvalid, axi.awlen, axi.awaddr, axi.awsize, wr_ready);
    end
    hs = 1'b0;
    for (int n = 0; n < 40 && !hs; n++) begin
      axi.awready = (n == 39) ? 1'b1 : 1'($urandom_range(0, 1));
      hs = axi.awready;
      tick();
      axi.awready = 1'b0;
      if (!hs) begin
        checks++;
        if (axi.awvalid !== 1'b1 || axi.awaddr !== 32'h0000_2000 || axi.awlen !== 4'd7) begin
          failures++;
          $display("FAIL wr8_aw_hold: awvalid=%b awaddr=%h awlen=%0d, required 1 00002000 7", axi.awvalid, axi.awaddr, axi.awlen);
        end
      end
    end
    beat = 0;
    for (int n = 0; n < 200 && beat < 8; n++) begin
      checks++;
      if (axi.wvalid !== 1'b1 || axi.wdata !== 32'(beat) || axi.wstrb !== 4'hF || axi.wlast !== (beat == 7)
          || axi.wid !== 4'b0001 || axi.awvalid !== 1'b0) begin
        failures++;
        $display("FAIL wr8_w%0d: wvalid=%b wdata=%h wstrb=%h wlast=%b wid=%h awvalid=%b, required 1 %h f %b 1 0",
                 beat, axi.wvalid, axi.wdata, axi.wstrb, axi.wlast, axi.wid, axi.awvalid, 32'(beat), (beat == 7));
      end
      axi.wready = 1'($urandom_range(0, 1));
      hs = axi.wready;
      tick();
      axi.wready = 1'b0;
      if (hs) beat++;
    end
    checks++;
    if (beat != 8 || axi.wvalid !== 1'b0) begin
      failures++;
      $display("FAIL wr8_w_end: beats=%0d wvalid=%b, required 8 0", beat, axi.wvalid);
    end
    axi.bvalid = 1'b1; axi.bid = 4'b0001; axi.bresp = 2'b00;
    tick();
    axi.bvalid = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL wr8_b: done=%b, required 0", done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || done_err !== 1'b0) begin
      failures++;
      $display("FAIL wr8_done: done=%b done_err=%b, required 1 0", done, done_err);
    end
    tick();
  endtask

  task automatic test_write_error();
    issue(1'b1, 32'h0000_3000, 2'd2, 4'd0);
    wr_valid = 1'b1; wr_data = 32'hCAFE_F00D; wr_strb = 4'h3;
    tick();
    wr_valid = 1'b0;
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
    checks++;
    if (axi.wvalid !== 1'b1 || axi.wlast !== 1'b1 || axi.wdata !== 32'hCAFE_F00D || axi.wstrb !== 4'h3) begin
      failures++;
      $display("FAIL wr1_w: wvalid=%b wlast=%b wdata=%h wstrb=%h, required 1 1 cafef00d 3", axi.wvalid, axi.wlast, axi.wdata, axi.wstrb);
    end
    axi.wready = 1'b1;
    tick();
    axi.wready = 1'b0;
    axi.bvalid = 1'b1; axi.bid = 4'b0001; axi.bresp = 2'b10;
    tick();
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    tick();
    checks++;
    if (done !== 1'b1 || done_err !== 1'b1) begin
      failures++;
      $display("FAIL wr1_slverr: done=%b done_err=%b, required 1 1", done, done_err);
    end
    quick_read(32'h0000_4000, 32'h1234_5678);
    checks++;
    if (done !== 1'b1 || done_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clears: done=%b done_err=%b, required 1 0", done, done_err);
    end
    tick();
  endtask

  task automatic test_illegal();
    issue(1'b0, 32'h0000_5000, 2'd2, 4'd8);
    checks++;
    if (axi.arvalid !== 1'b0 || axi.awvalid !== 1'b0 || done !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL ill_len_bus: arvalid=%b awvalid=%b done=%b req_ready=%b, required 0 0 0 0", axi.arvalid, axi.awvalid, done, req_ready);
    end
    tick();
    checks++;
    if (done !== 1'b1 || done_err !== 1'b1 || axi.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL ill_len_done: done=%b done_err=%b arvalid=%b, required 1 1 0", done, done_err, axi.arvalid);
    end
    tick();
    issue(1'b1, 32'h0000_6000, 2'd3, 4'd0);
    checks++;
    if (wr_ready !== 1'b0 || axi.awvalid !== 1'b0) begin
      failures++;
      $display("FAIL ill_size_bus: wr_ready=%b awvalid=%b, required 0 0", wr_ready, axi.awvalid);
    end
    tick();
    checks++;
    if (done !== 1'b1 || done_err !== 1'b1) begin
      failures++;
      $display("FAIL ill_size_done: done=%b done_err=%b, required 1 1", done, done_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    issue(1'b1, 32'h0000_7000, 2'd2, 4'd7);
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = 32'd100 + 32'(i); wr_strb = 4'hF;
      tick();
    end
    wr_valid = 1'b0;
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
    axi.wready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (axi.wvalid !== 1'b1 || axi.wdata !== 32'd103) begin
      failures++;
      $display("FAIL rst_w3: wvalid=%b wdata=%0d, required 1 103", axi.wvalid, axi.wdata);
    end
    aresetn = 1'b0;
    #1;
    axi.wready = 1'b0;
    checks++;
    if (axi.wvalid !== 1'b0 || axi.wlast !== 1'b0 || axi.awvalid !== 1'b0 || axi.arvalid !== 1'b0
        || done !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_abort: wvalid=%b wlast=%b awvalid=%b arvalid=%b done=%b req_ready=%b, required 0 0 0 0 0 1",
               axi.wvalid, axi.wlast, axi.awvalid, axi.arvalid, done, req_ready);
    end
    tick();
    aresetn = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_release: req_ready=%b done=%b, required 1 0", req_ready, done);
    end
    quick_read(32'h0000_8000, 32'h0BAD_F00D);
    checks++;
    if (done !== 1'b1 || done_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_recover: done=%b done_err=%b, required 1 0", done, done_err);
    end
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    aresetn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; wr_strb = '0;
    axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
    axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;
    test_reset();
    test_read_single();
    test_read_burst();
    test_write_burst();
    test_write_error();
    test_illegal();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
